servo_pwm_gen: RTL and testbench
================================

# servo_pwm_gen

Servo pulse generator that consumes the control words held in the servo IP's AXI4-Lite register file and drives one hobby-servo PWM line. It latches period and pulse width into shadow registers at each period boundary, so outputs are glitch-free when software writes mid-period. It sits directly downstream of the AXI4-Lite slave register bank, inside the servo IP.

## Interface
- CNT_WIDTH, 24: width of the period/pulse counter (2,000,000 cycles = 20 ms at 100 MHz fits).
- ACLK  in  1  clock; all logic is on the rising edge.
- ARESET  in  1  synchronous, active-high reset.
- ctrl_enable  in  1  register 0 bit 0; starts or stops pulse generation.
- ctrl_invert  in  1  register 0 bit 1; inverts pwm_out polarity (idle level follows).
- period_cycles  in  CNT_WIDTH  register 1; PWM period in ACLK cycles.
- pulse_cycles  in  CNT_WIDTH  register 2; target high time in ACLK cycles.
- slew_step  in  CNT_WIDTH  register 3; maximum pulse change per period, 0 = unlimited. Used only with SERVO_SLEW_EN.
- pwm_out  out  1  servo drive, registered.
- period_tick  out  1  one-cycle strobe in the last cycle of each period.
- busy  out  1  high while not in IDLE.
- cfg_err  out  1  sticky flag: period_cycles < 2 seen at a load point. Cleared by ARESET or by ctrl_enable = 0.
- pulse_eff  out  CNT_WIDTH  pulse width currently in use (readback for register 3 status).

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE: cnt = 0, pwm_out = ctrl_invert. On ctrl_enable = 1:
  - If period_cycles ≥ 2: load shadow_period and shadow_pulse, go to RUN.
  - Otherwise set cfg_err and stay in IDLE.
- RUN: cnt increments by 1 from 0 to shadow_period − 1, then wraps.
  - Raw output is (cnt < shadow_pulse); pwm_out = raw XOR ctrl_invert.
- Clamping: shadow_pulse is min(pulse_cycles, shadow_period). pulse = 0 gives a constant low; pulse ≥ period gives a constant high. In both cases period_tick continues.
- Period end (cnt == shadow_period − 1):
  - period_tick = 1.
  - If ctrl_enable = 1 and period_cycles ≥ 2: reload shadows and stay in RUN.
  - If period_cycles < 2: set cfg_err, keep the old shadows and stay in RUN.
  - If ctrl_enable = 0: go to IDLE.
- Disable mid-period: the current period completes (no runt pulse), then IDLE. DRAIN is the state between ctrl_enable falling and the period end; in DRAIN the shadows are not reloaded.
- Re-enable during DRAIN: return to RUN at the period end with no idle gap.
- Register writes mid-period take effect only at the next load point.
- ARESET at any time: IDLE, cnt = 0, shadows = 0, pulse_eff = 0, cfg_err = 0, pwm_out = 0, period_tick = 0, busy = 0.

## Timing
- Output reset values: pwm_out 0, period_tick 0, busy 0, cfg_err 0, pulse_eff 0.
- Enable latency: ctrl_enable is sampled high at edge N; busy and the first pwm_out high level appear after edge N+1.
- Period length is exactly shadow_period cycles. The high time is exactly shadow_pulse cycles, starting in the first cycle of the period.
- period_tick is asserted in the same cycle as the last count value.
- The new shadow values apply from the first cycle of the next period.
- ctrl_invert is not shadowed; it takes effect one cycle after it changes.

## Configuration
- SERVO_SLEW_EN defined:
  - At each load point, pulse_eff moves toward the clamped pulse_cycles by at most slew_step.
  - slew_step = 0 jumps directly to the target.
  - The step arithmetic is CNT_WIDTH+1 bits wide and saturates at 0 and at shadow_period.
  - At the first load from IDLE, pulse_eff starts at the target (no ramp).
- SERVO_SLEW_EN undefined: pulse_eff = clamped pulse_cycles at each load, and slew_step is ignored. The port is kept so the block-design wrapper is unchanged.

## Structure
- Package servo_pkg holds:
  - the FSM state enum (IDLE, RUN, DRAIN);
  - the CTRL_ENABLE_BIT = 0 and CTRL_INVERT_BIT = 1 constants;
  - the register offsets 0x0, 0x4, 0x8, 0xC.
- One sub-module, servo_slew_limiter: a combinational/registered step toward the target, instantiated only under SERVO_SLEW_EN.
- The counter, FSM and shadow logic stay in servo_pwm_gen.

## Test plan
- Basic: period 20, pulse 5, enable → pwm_out high for 5 cycles and low for 15, period_tick every 20 cycles; first high level one cycle after enable is sampled.
- Mid-period update: pulse changed 5→12 at cnt = 3 → current period still 5 high; next period 12 high.
- Boundaries: pulse 0 → pwm_out constant 0. Pulse 25 with period 20 → pwm_out constant 1 and pulse_eff = 20. Period 1 at enable → cfg_err = 1 and busy = 0.
- Disable at cnt = 7 (pulse 5) → period runs to cnt = 19, then IDLE with pwm_out = 0. Re-enable at cnt = 15 → no idle gap between periods.
- ARESET asserted at cnt = 2 of a high phase → next cycle pwm_out = 0, busy = 0, cfg_err = 0; after release, enable restarts from cnt = 0.
- Slew (SERVO_SLEW_EN): period 20, pulse 5→15, slew_step 4 → successive periods 5, 9, 13, 15. Without the macro → 5, 15.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared definitions for the servo PWM generator: FSM states, control bit
// positions and register offsets within the servo IP's AXI4-Lite bank.
package servo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } servo_state_e;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_INVERT_BIT = 1;

    localparam logic [3:0] REG_CTRL_OFS   = 4'h0;
    localparam logic [3:0] REG_PERIOD_OFS = 4'h4;
    localparam logic [3:0] REG_PULSE_OFS  = 4'h8;
    localparam logic [3:0] REG_SLEW_OFS   = 4'hC;

endpackage

// File: rtl/servo_slew_limiter.sv
// One slew step of the effective pulse width toward its target, computed one
// bit wider than the counter and saturated at 0 and at the period.
module servo_slew_limiter #(
    parameter int CNT_WIDTH = 24
) (
    input  logic [CNT_WIDTH-1:0] cur_pulse,
    input  logic [CNT_WIDTH-1:0] target_pulse,
    input  logic [CNT_WIDTH-1:0] step,
    input  logic [CNT_WIDTH-1:0] limit,
    output logic [CNT_WIDTH-1:0] next_pulse
);

    logic [CNT_WIDTH:0] up_sum;
    logic [CNT_WIDTH:0] dn_diff;
    logic [CNT_WIDTH:0] cand;

    always_comb begin
        up_sum  = {1'b0, cur_pulse} + {1'b0, step};
        dn_diff = {1'b0, cur_pulse} - {1'b0, step};
        if (step == '0) begin
            cand = {1'b0, target_pulse};
        end else if (target_pulse > cur_pulse) begin
            cand = (up_sum > {1'b0, target_pulse}) ? {1'b0, target_pulse} : up_sum;
        end else if (dn_diff[CNT_WIDTH] || (dn_diff < {1'b0, target_pulse})) begin
            // a borrow out of the top bit means the step overshot below zero
            cand = {1'b0, target_pulse};
        end else begin
            cand = dn_diff;
        end
        if (cand > {1'b0, limit}) begin
            cand = {1'b0, limit};
        end
        next_pulse = cand[CNT_WIDTH-1:0];
    end

endmodule

// File: rtl/servo_pwm_gen.sv
// Hobby-servo PWM generator with period-boundary shadowing of period/pulse.
// Define SERVO_SLEW_EN to rate-limit pulse changes by slew_step per period.
module servo_pwm_gen
    import servo_pkg::*;
#(
    parameter int CNT_WIDTH = 24
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic                 ctrl_enable,
    input  logic                 ctrl_invert,
    input  logic [CNT_WIDTH-1:0] period_cycles,
    input  logic [CNT_WIDTH-1:0] pulse_cycles,
    input  logic [CNT_WIDTH-1:0] slew_step,
    output logic                 pwm_out,
    output logic                 period_tick,
    output logic                 busy,
    output logic                 cfg_err,
    output logic [CNT_WIDTH-1:0] pulse_eff
);

    function automatic logic [CNT_WIDTH-1:0] clamp_pulse(
        input logic [CNT_WIDTH-1:0] pulse,
        input logic [CNT_WIDTH-1:0] lim
    );
        return (pulse > lim) ? lim : pulse;
    endfunction

    servo_state_e         state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] shadow_period_q, shadow_period_d;
    logic [CNT_WIDTH-1:0] shadow_pulse_q, shadow_pulse_d;
    logic                 cfg_err_q, cfg_err_d;
    logic                 pwm_q, pwm_d;
    logic                 tick_q, tick_d;
    logic                 busy_q, busy_d;

    logic [CNT_WIDTH-1:0] target_pulse;
    logic [CNT_WIDTH-1:0] slewed_pulse;
    logic                 period_ok;
    logic                 last_cnt;
    logic                 load;

    assign target_pulse = clamp_pulse(pulse_cycles, period_cycles);
    assign period_ok    = (period_cycles >= CNT_WIDTH'(2));
    assign last_cnt     = (cnt_q == shadow_period_q - CNT_WIDTH'(1));

`ifdef SERVO_SLEW_EN
    servo_slew_limiter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_slew (
        .cur_pulse   (shadow_pulse_q),
        .target_pulse(target_pulse),
        .step        (slew_step),
        .limit       (period_cycles),
        .next_pulse  (slewed_pulse)
    );
`else
    logic unused_slew_step;
    assign unused_slew_step = ^slew_step;
    assign slewed_pulse     = target_pulse;
`endif

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        shadow_period_d = shadow_period_q;
        shadow_pulse_d  = shadow_pulse_q;
        cfg_err_d       = cfg_err_q;
        load            = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (ctrl_enable) begin
                    if (period_ok) begin
                        load    = 1'b1;
                        state_d = RUN;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            RUN, DRAIN: begin
                if (last_cnt) begin
                    cnt_d = '0;
                    if (ctrl_enable) begin
                        // a re-enable during DRAIN lands here too: no idle gap
                        state_d = RUN;
                        if (period_ok) begin
                            load = 1'b1;
                        end else begin
                            cfg_err_d = 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                    if (state_q == RUN && !ctrl_enable) begin
                        state_d = DRAIN;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (load) begin
            shadow_period_d = period_cycles;
            // the first load from IDLE starts directly at the target
            shadow_pulse_d  = (state_q == IDLE) ? target_pulse : slewed_pulse;
        end

        if (!ctrl_enable) begin
            cfg_err_d = 1'b0;
        end

        pwm_d  = (state_q == IDLE) ? ctrl_invert : ((cnt_q < shadow_pulse_q) ^ ctrl_invert);
        tick_d = (state_q != IDLE) && last_cnt;
        busy_d = (state_q != IDLE);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            shadow_period_q <= '0;
            shadow_pulse_q  <= '0;
            cfg_err_q       <= 1'b0;
            pwm_q           <= 1'b0;
            tick_q          <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            shadow_period_q <= shadow_period_d;
            shadow_pulse_q  <= shadow_pulse_d;
            cfg_err_q       <= cfg_err_d;
            pwm_q           <= pwm_d;
            tick_q          <= tick_d;
            busy_q          <= busy_d;
        end
    end

    assign pwm_out     = pwm_q;
    assign period_tick = tick_q;
    assign busy        = busy_q;
    assign cfg_err     = cfg_err_q;
    assign pulse_eff   = shadow_pulse_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Directed bench for servo_pwm_gen; expected waveforms are hand-derived per cycle.
module tb_servo_pwm_gen;

    localparam int CW = 24;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic          ctrl_enable;
    logic          ctrl_invert;
    logic [CW-1:0] period_cycles;
    logic [CW-1:0] pulse_cycles;
    logic [CW-1:0] slew_step;
    logic          pwm_out;
    logic          period_tick;
    logic          busy;
    logic          cfg_err;
    logic [CW-1:0] pulse_eff;

    int errors = 0;
    int checks = 0;

    servo_pwm_gen #(.CNT_WIDTH(CW)) dut (
        .ACLK         (ACLK),
        .ARESET       (ARESET),
        .ctrl_enable  (ctrl_enable),
        .ctrl_invert  (ctrl_invert),
        .period_cycles(period_cycles),
        .pulse_cycles (pulse_cycles),
        .slew_step    (slew_step),
        .pwm_out      (pwm_out),
        .period_tick  (period_tick),
        .busy         (busy),
        .cfg_err      (cfg_err),
        .pulse_eff    (pulse_eff)
    );

    always #5 ACLK = ~ACLK;

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Walks count positions first..last of a running period: pwm shows cnt<hi,
    // tick marks the last count, busy stays high throughout.
    task automatic span(input int first, input int last, input int hi, input int per,
                        input string tag);
        for (int i = first; i <= last; i++) begin
            step();
            chk($sformatf("%s/pwm@%0d", tag, i), {31'd0, pwm_out}, (i < hi) ? 32'd1 : 32'd0);
            chk($sformatf("%s/tick@%0d", tag, i), {31'd0, period_tick},
                (i == per - 1) ? 32'd1 : 32'd0);
            chk($sformatf("%s/busy@%0d", tag, i), {31'd0, busy}, 32'd1);
        end
    endtask

    initial begin
        ARESET        = 1'b1;
        ctrl_enable   = 1'b0;
        ctrl_invert   = 1'b0;
        period_cycles = '0;
        pulse_cycles  = '0;
        slew_step     = '0;
        step(); step(); step();
        chk("rst/pwm", {31'd0, pwm_out}, 32'd0);
        chk("rst/tick", {31'd0, period_tick}, 32'd0);
        chk("rst/busy", {31'd0, busy}, 32'd0);
        chk("rst/err", {31'd0, cfg_err}, 32'd0);
        chk("rst/eff", {8'd0, pulse_eff}, 32'd0);

        // basic: period 20, pulse 5
        ARESET = 1'b0;
        step();
        period_cycles = 24'd20;
        pulse_cycles  = 24'd5;
        ctrl_enable   = 1'b1;
        step();
        chk("en/busy_lag", {31'd0, busy}, 32'd0);
        chk("en/pwm_lag", {31'd0, pwm_out}, 32'd0);
        chk("en/eff", {8'd0, pulse_eff}, 32'd5);
        span(0, 19, 5, 20, "basic1");
        span(0, 19, 5, 20, "basic2");

        // mid-period update 5 -> 12 at cnt 3
        span(0, 2, 5, 20, "mid_a");
        pulse_cycles = 24'd12;
        span(3, 19, 5, 20, "mid_b");
        chk("mid/eff", {8'd0, pulse_eff}, 32'd12);
        span(0, 19, 12, 20, "mid_c");

        // pulse 0 and pulse beyond period
        pulse_cycles = 24'd0;
        span(0, 19, 12, 20, "zero_a");
        chk("zero/eff", {8'd0, pulse_eff}, 32'd0);
        pulse_cycles = 24'd25;
        span(0, 19, 0, 20, "zero_b");
        chk("clamp/eff", {8'd0, pulse_eff}, 32'd20);
        pulse_cycles = 24'd5;
        span(0, 19, 20, 20, "clamp");

        // disable at cnt 7: period completes, then idle
        span(0, 6, 5, 20, "drain_a");
        ctrl_enable = 1'b0;
        span(7, 19, 5, 20, "drain_b");
        step();
        chk("idle/pwm", {31'd0, pwm_out}, 32'd0);
        chk("idle/busy", {31'd0, busy}, 32'd0);
        chk("idle/tick", {31'd0, period_tick}, 32'd0);

        // idle level follows invert
        ctrl_invert = 1'b1;
        step();
        chk("inv/idle_pwm", {31'd0, pwm_out}, 32'd1);
        ctrl_invert = 1'b0;
        step();
        chk("inv/idle_pwm0", {31'd0, pwm_out}, 32'd0);

        // disable at cnt 10, re-enable at cnt 15: no idle gap
        ctrl_enable = 1'b1;
        step();
        span(0, 9, 5, 20, "reen_a");
        ctrl_enable = 1'b0;
        span(10, 14, 5, 20, "reen_b");
        ctrl_enable = 1'b1;
        span(15, 19, 5, 20, "reen_c");
        span(0, 19, 5, 20, "reen_d");

        // period 1 at enable from idle
        ctrl_enable = 1'b0;
        span(0, 19, 5, 20, "stop");
        step();
        chk("stop/busy", {31'd0, busy}, 32'd0);
        period_cycles = 24'd1;
        ctrl_enable   = 1'b1;
        step();
        chk("p1/err", {31'd0, cfg_err}, 32'd1);
        step();
        chk("p1/busy", {31'd0, busy}, 32'd0);
        chk("p1/pwm", {31'd0, pwm_out}, 32'd0);
        chk("p1/err_hold", {31'd0, cfg_err}, 32'd1);
        ctrl_enable = 1'b0;
        step();
        chk("p1/err_clr", {31'd0, cfg_err}, 32'd0);

        // bad period at a running load point keeps old shadows; then reset mid-high
        period_cycles = 24'd20;
        ctrl_enable   = 1'b1;
        step();
        period_cycles = 24'd1;
        span(0, 19, 5, 20, "badp");
        chk("badp/err", {31'd0, cfg_err}, 32'd1);
        period_cycles = 24'd20;
        span(0, 1, 5, 20, "pre_rst");
        ARESET = 1'b1;
        step();
        chk("arst/pwm", {31'd0, pwm_out}, 32'd0);
        chk("arst/busy", {31'd0, busy}, 32'd0);
        chk("arst/err", {31'd0, cfg_err}, 32'd0);
        chk("arst/eff", {8'd0, pulse_eff}, 32'd0);
        chk("arst/tick", {31'd0, period_tick}, 32'd0);
        ARESET = 1'b0;
        step();
        span(0, 19, 5, 20, "restart");

        // slew 5 -> 15 with step 4
        slew_step    = 24'd4;
        pulse_cycles = 24'd15;
        span(0, 19, 5, 20, "slew0");
`ifdef SERVO_SLEW_EN
        chk("slew/eff1", {8'd0, pulse_eff}, 32'd9);
        span(0, 19, 9, 20, "slew1");
        chk("slew/eff2", {8'd0, pulse_eff}, 32'd13);
        span(0, 19, 13, 20, "slew2");
        chk("slew/eff3", {8'd0, pulse_eff}, 32'd15);
        span(0, 19, 15, 20, "slew3");
`else
        chk("slew/eff1", {8'd0, pulse_eff}, 32'd15);
        span(0, 19, 15, 20, "slew1");
        chk("slew/eff2", {8'd0, pulse_eff}, 32'd15);
        span(0, 19, 15, 20, "slew2");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
